// File: rtl/uart_tx_core_if.sv
// Handshake, configuration and line signals between a byte source and uart_tx_core.
interface uart_tx_core_if;
  logic       br_tick8x;
  logic       parity_en;
  logic       parity_even;
  logic       dat_valid;
  logic [7:0] dat;
  logic       dat_ack;
  logic       busy;
  logic       tx_done;
  logic       tx;

  modport master (
    output br_tick8x, parity_en, parity_even, dat_valid, dat,
    input  dat_ack, busy, tx_done, tx
  );

  modport slave (
    input  br_tick8x, parity_en, parity_even, dat_valid, dat,
    output dat_ack, busy, tx_done, tx
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmit core: start bit, 8 data bits LSB first, optional parity, stop bit(s).
// Bit timing comes from an external oversampling tick; tx is registered and idles high.
module uart_tx_core #(
  parameter int unsigned TicksPerBit = 8,
  parameter int unsigned StopBits    = 1
) (
  input logic           clk,
  input logic           rst,
  uart_tx_core_if.slave bus
);

  localparam int unsigned CntW = $clog2(TicksPerBit);
  localparam logic [CntW-1:0] TickMax = CntW'(TicksPerBit - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic [7:0]      shadow_q, shadow_d;
  logic            par_en_q, par_en_d;
  logic            par_even_q, par_even_d;
  logic            tx_q, tx_d;
  logic            bit_end, last_stop, ack, done;

  assign bit_end   = (state_q != StIdle) && bus.br_tick8x && (tick_cnt_q == TickMax);
  assign last_stop = (StopBits == 32'd1) || stop_cnt_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shadow_d   = shadow_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    ack        = 1'b0;
    done       = 1'b0;

    // Ticks only advance the bit timer while a frame is in flight.
    if (state_q != StIdle && bus.br_tick8x) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.dat_valid) begin
          shadow_d   = bus.dat;
          par_en_d   = bus.parity_en;
          par_even_d = bus.parity_even;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          ack        = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            stop_cnt_d = 1'b0;
            state_d    = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (last_stop) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is derived from the next state so tx changes on the same edge as the FSM.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shadow_d[bit_cnt_d];
      StParity: tx_d = par_even_d ? ^shadow_d : ~^shadow_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shadow_q   <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shadow_q   <= shadow_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.dat_ack = ack & ~rst;
  assign bus.tx_done = done & ~rst;
  assign bus.busy    = (state_q != StIdle);
  assign bus.tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Randomized bench for uart_tx_core checked cycle by cycle against a frame-level bit-list model.
module tb_uart_tx_core;

  localparam int T = 8;

  logic clk;
  logic rst;

  uart_tx_core_if bus ();

  uart_tx_core #(
    .TicksPerBit(T),
    .StopBits   (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame model: expected line levels of the current frame, one entry per bit period.
  bit   m_in_frame = 1'b0;
  int   m_nticks   = 0;
  bit   m_bits[$];
  logic exp_busy = 1'b0;
  logic exp_tx   = 1'b1;

  logic [7:0] q_dat[$];
  bit         q_pen[$];
  bit         q_peven[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_frame(input logic [7:0] d, input bit pen, input bit peven);
    int ones = 0;
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      m_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) m_bits.push_back(peven ? bit'(ones % 2) : bit'(1 - ones % 2));
    m_bits.push_back(1'b1);
  endtask

  // One clock: check registered outputs, drive inputs, check pulses, advance the model.
  task automatic step(input bit tick, input bit valid, input logic [7:0] d, input bit pen,
                      input bit peven, input bit r, output bit acc);
    bit e_ack, e_done;
    @(negedge clk);
    check("busy", bus.busy, exp_busy);
    check("tx", bus.tx, exp_tx);
    rst             = r;
    bus.br_tick8x   = tick;
    bus.dat_valid   = valid;
    bus.dat         = d;
    bus.parity_en   = pen;
    bus.parity_even = peven;
    #1;
    e_ack  = !r && !m_in_frame && valid;
    e_done = !r && m_in_frame && tick && (m_nticks + 1 == m_bits.size() * T);
    check("dat_ack", bus.dat_ack, e_ack);
    check("tx_done", bus.tx_done, e_done);
    acc = e_ack;
    if (r) begin
      m_in_frame = 1'b0;
    end else if (e_ack) begin
      build_frame(d, pen, peven);
      m_in_frame = 1'b1;
      m_nticks   = 0;
    end else if (m_in_frame && tick) begin
      m_nticks++;
      if (m_nticks == m_bits.size() * T) m_in_frame = 1'b0;
    end
    exp_busy = m_in_frame;
    exp_tx   = m_in_frame ? m_bits[m_nticks / T] : 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input bit pen, input bit peven);
    q_dat.push_back(d);
    q_pen.push_back(pen);
    q_peven.push_back(peven);
  endtask

  // Feed queued bytes until all are sent; inputs are scrambled while a frame is in flight.
  task automatic drain(input int per, input bit gaps, input int abort_bit);
    int cyc     = 0;
    bit aborted = 1'b0;
    bit acc, tick, valid, r;
    while ((q_dat.size() > 0 || m_in_frame) && cyc < 30000) begin
      tick  = (per <= 1) ? 1'b1 : ($urandom_range(per - 1) == 0);
      valid = (q_dat.size() > 0) && (!gaps || m_in_frame || $urandom_range(3) == 0);
      r     = !aborted && abort_bit >= 0 && m_in_frame && (m_nticks / T == abort_bit);
      if (r) aborted = 1'b1;
      if (m_in_frame || !valid)
        step(tick, valid, 8'($urandom), 1'($urandom), 1'($urandom), r, acc);
      else
        step(tick, valid, q_dat[0], q_pen[0], q_peven[0], r, acc);
      if (acc) begin
        void'(q_dat.pop_front());
        void'(q_pen.pop_front());
        void'(q_peven.pop_front());
      end
      cyc++;
    end
    check("drain_timeout", 32'(cyc >= 30000), 32'd0);
  endtask

  initial begin
    bit acc;
    rst             = 1'b1;
    bus.br_tick8x   = 1'b0;
    bus.dat_valid   = 1'b0;
    bus.dat         = 8'h00;
    bus.parity_en   = 1'b0;
    bus.parity_even = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state, including a request that must not be acknowledged under reset.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 1'b1, 8'hff, 1'b1, 1'b1, 1'b1, acc);
    // Idle ticks with no request.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);

    push(8'h55, 1'b0, 1'b0);
    drain(3, 1'b0, -1);

    push(8'hA3, 1'b1, 1'b1);
    push(8'hA3, 1'b1, 1'b0);
    drain(2, 1'b0, -1);

    // Held dat_valid, back-to-back frames with tick every clock.
    for (int i = 0; i < 3; i++) push(8'($urandom), 1'($urandom), 1'($urandom));
    drain(1, 1'b0, -1);

    // Abort during data bit 4, then a clean frame.
    push(8'($urandom), 1'b1, 1'b0);
    drain(2, 1'b0, 5);
    push(8'hC6, 1'b1, 1'b1);
    drain(2, 1'b0, -1);

    for (int i = 0; i < 40; i++) push(8'($urandom), 1'($urandom), 1'($urandom));
    drain(int'($urandom_range(4, 1)), 1'b1, -1);
    for (int i = 0; i < 4; i++) push(8'($urandom), 1'($urandom), 1'($urandom));
    drain(3, 1'b1, -1);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
